// File: rtl/di_tx_pkg.sv
// -----------------------------------------------------------------------------
// di_tx_pkg
// Shared definitions for the 1-of-4 delay-insensitive transmitter.
//   - di_tx_state_e : handshake FSM states (IDLE, DATA, NULL)
//   - GROUP_W       : rails per digit group (one-hot, 4)
//   - DIGIT_W       : data bits per digit group (2)
//   - MAX_WIDTH     : widest data word the encode helper supports
//   - encode_1of4() : data word -> rail vector, one hot rail per 2-bit digit
//   - null_rails()  : the all-zero (NULL) rail vector
// -----------------------------------------------------------------------------
package di_tx_pkg;

  localparam int unsigned GROUP_W   = 4;
  localparam int unsigned DIGIT_W   = 2;
  localparam int unsigned MAX_WIDTH = 64;
  localparam int unsigned MAX_RAILS = 2 * MAX_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_NULL = 2'd2
  } di_tx_state_e;

  // Encodes a word of up to MAX_WIDTH bits. Callers zero-extend their word and
  // truncate the result to 2*WIDTH rails; unused upper groups encode digit 0
  // and are dropped by the truncation.
  function automatic logic [MAX_RAILS-1:0] encode_1of4(input logic [MAX_WIDTH-1:0] word);
    logic [MAX_RAILS-1:0] rails;
    logic [DIGIT_W-1:0]   digit;
    logic [GROUP_W-1:0]   hot;
    rails = '0;
    for (int unsigned g = 0; g < MAX_WIDTH / DIGIT_W; g++) begin
      digit = DIGIT_W'(word >> (g * DIGIT_W));
      hot   = GROUP_W'(1) << digit;
      rails = rails | (MAX_RAILS'(hot) << (g * GROUP_W));
    end
    return rails;
  endfunction

  function automatic logic [MAX_RAILS-1:0] null_rails();
    return '0;
  endfunction

endpackage

// File: rtl/di_tx_1of4_sync.sv
// -----------------------------------------------------------------------------
// di_sync
// STAGES-deep flop chain bringing an asynchronous level into the clk domain.
// Asynchronous active-low reset clears every stage to 0.
// Ports:
//   clk   in  : destination clock
//   rst_n in  : asynchronous active-low reset
//   i_d   in  : asynchronous input level
//   o_q   out : synchronized level (last stage)
// -----------------------------------------------------------------------------
module di_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/di_tx_1of4.sv
// -----------------------------------------------------------------------------
// di_tx_1of4
// Synchronous sender for the delay-insensitive 1-of-4 four-phase link.
// Words arrive over valid/ready into a one-entry holding buffer, are encoded
// one hot rail per 2-bit digit, and are launched onto registered rails. The
// return-to-zero handshake runs against an asynchronous acknowledge that is
// synchronized before the FSM looks at it.
//
// Optional feature: define DI_TX_TIMEOUT_EN to build the handshake watchdog;
// otherwise timeout_err is tied low.
//
// Parameters:
//   WIDTH       : data word width (even, 2..64); 2*WIDTH rails
//   SYNC_STAGES : ack_in synchronizer depth (>= 2)
//   TIMEOUT     : watchdog limit in cycles (only with DI_TX_TIMEOUT_EN)
// Ports:
//   clk         in  : clock
//   rst_n       in  : asynchronous active-low reset
//   in_data     in  : word to send, sampled only on the accept edge
//   in_valid    in  : in_data valid
//   in_ready    out : holding buffer empty
//   rails_out   out : registered rails, group g at [4g+3:4g]
//   ack_in      in  : receiver acknowledge, asynchronous to clk
//   busy        out : FSM not IDLE or buffer full
//   timeout_err out : sticky watchdog flag
// -----------------------------------------------------------------------------
module di_tx_1of4
  import di_tx_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] rails_out,
  input  logic               ack_in,
  output logic               busy,
  output logic               timeout_err
);

  localparam int unsigned RAILS = 2 * WIDTH;

  if ((WIDTH % 2) != 0 || WIDTH < 2 || WIDTH > MAX_WIDTH ||
      SYNC_STAGES < 2 || TIMEOUT < 1) begin : g_bad_params
    $error("di_tx_1of4: illegal WIDTH/SYNC_STAGES/TIMEOUT");
  end

  di_tx_state_e     r_state;
  logic [RAILS-1:0] r_rails;
  logic             r_buf_full;
  logic [WIDTH-1:0] r_buf_data;

  logic             w_ack_s;
  logic             w_load;
  logic             w_accept;
  logic [RAILS-1:0] w_enc;

  di_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (ack_in),
    .o_q   (w_ack_s)
  );

  assign w_enc = RAILS'(encode_1of4(MAX_WIDTH'(r_buf_data)));

  // A buffered word launches from either rail-NULL state once the receiver
  // has released ack; a stale ack in IDLE simply holds the word back.
  assign w_load   = r_buf_full && !w_ack_s &&
                    ((r_state == ST_IDLE) || (r_state == ST_NULL));
  assign w_accept = in_valid && !r_buf_full;

  // Holding buffer: accept and drain are mutually exclusive because a drain
  // needs the buffer full while an accept needs it empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_full <= 1'b0;
      r_buf_data <= '0;
    end else if (w_load) begin
      r_buf_full <= 1'b0;
    end else if (w_accept) begin
      r_buf_full <= 1'b1;
      r_buf_data <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_rails <= RAILS'(null_rails());
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_rails <= RAILS'(null_rails());
          if (w_load) begin
            r_rails <= w_enc;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_ack_s) begin
            r_rails <= RAILS'(null_rails());
            r_state <= ST_NULL;
          end
        end
        ST_NULL: begin
          if (!w_ack_s) begin
            if (r_buf_full) begin
              r_rails <= w_enc;
              r_state <= ST_DATA;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_rails <= RAILS'(null_rails());
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rails_out = r_rails;
  assign in_ready  = !r_buf_full;
  assign busy      = (r_state != ST_IDLE) || r_buf_full;

`ifdef DI_TX_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_wd_cnt;
  logic             r_timeout_err;
  logic             w_state_change;

  // Mirrors every transition condition of the FSM above so the counter
  // clears on exactly the edges where the state moves.
  assign w_state_change = ((r_state == ST_IDLE) && w_load)   ||
                          ((r_state == ST_DATA) && w_ack_s)  ||
                          ((r_state == ST_NULL) && !w_ack_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else if (w_state_change || (r_state == ST_IDLE)) begin
      r_wd_cnt <= '0;
    end else if (r_wd_cnt != CNT_W'(TIMEOUT)) begin
      r_wd_cnt <= r_wd_cnt + CNT_W'(1);
      if ((r_wd_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT)) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_di_tx_1of4.sv
// -----------------------------------------------------------------------------
// tb_di_tx_1of4
// Self-checking bench for di_tx_1of4 (WIDTH=8, SYNC_STAGES=2, TIMEOUT=10).
// A link-level model tracks the words waiting to be sent, the receiver's ack
// as seen through the synchronizer delay, and the rail phase; it is compared
// with the DUT after every clock edge. Directed sequences pin the model with
// hand-computed rail values, then a random soak with a random-delay receiver
// exercises the handshake.
// -----------------------------------------------------------------------------
module tb_di_tx_1of4;

  localparam int W    = 8;
  localparam int RW   = 2 * W;
  localparam int SYNC = 2;
  localparam int TMO  = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [RW-1:0] rails_out;
  logic          ack_in = 1'b0;
  logic          busy;
  logic          timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  di_tx_1of4 #(
    .WIDTH       (W),
    .SYNC_STAGES (SYNC),
    .TIMEOUT     (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .rails_out   (rails_out),
    .ack_in      (ack_in),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Rail g*4+v high for digit v of group g.
  function automatic logic [RW-1:0] enc(input logic [W-1:0] w);
    logic [RW-1:0] r;
    int v;
    r = '0;
    for (int g = 0; g < W / 2; g++) begin
      v = (w >> (2 * g)) & 3;
      r = r | (RW'(1) << (4 * g + v));
    end
    return r;
  endfunction

  // Legal rails: all zero, or every group exactly one-hot.
  function automatic bit rails_legal(input logic [RW-1:0] r);
    int ones;
    if (r == '0) return 1'b1;
    for (int g = 0; g < W / 2; g++) begin
      ones = $countones((r >> (4 * g)) & 16'hF);
      if (ones != 1) return 1'b0;
    end
    return 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Link model: pending words, delayed ack, rail value, return-to-zero phase.
  // ---------------------------------------------------------------------------
  logic [W-1:0]  m_q[$];
  bit            m_ack_line[SYNC];
  logic [RW-1:0] m_rails;
  bit            m_rtz;
  bit            m_err;
  int            m_phase;
  int            m_stay;

  task automatic m_reset();
    m_q.delete();
    for (int i = 0; i < SYNC; i++) m_ack_line[i] = 1'b0;
    m_rails = '0;
    m_rtz   = 1'b0;
    m_err   = 1'b0;
    m_phase = 0;
    m_stay  = 0;
  endtask

  initial begin : monitor
    logic          pv;
    logic [W-1:0]  pd;
    logic          pa;
    bit            ack_pre;
    bit            ready_pre;
    logic [RW-1:0] nxt;
    logic [RW-1:0] prev_dut;
    int            new_phase;
    prev_dut = '0;
    m_reset();
    forever begin
      @(posedge clk);
      pv = in_valid;
      pd = in_data;
      pa = ack_in;
      #1;
      if (!rst_n) begin
        m_reset();
        prev_dut = '0;
        continue;
      end
      ack_pre = m_ack_line[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) m_ack_line[i] = m_ack_line[i-1];
      m_ack_line[0] = pa;
      ready_pre = (m_q.size() == 0);

      if (m_rails != '0) begin
        if (ack_pre) begin
          nxt   = '0;
          m_rtz = 1'b1;
        end else begin
          nxt = m_rails;
        end
      end else if ((m_q.size() > 0) && !ack_pre) begin
        nxt   = enc(m_q.pop_front());
        m_rtz = 1'b0;
      end else begin
        nxt = '0;
        if (!ack_pre) m_rtz = 1'b0;
      end
      if (pv && ready_pre) m_q.push_back(pd);
      m_rails = nxt;

      new_phase = (nxt != '0) ? 1 : (m_rtz ? 2 : 0);
      if ((new_phase == m_phase) && (new_phase != 0)) begin
        if (m_stay < TMO) m_stay++;
      end else begin
        m_stay = 0;
      end
      m_phase = new_phase;
`ifdef DI_TX_TIMEOUT_EN
      if (m_stay == TMO) m_err = 1'b1;
`endif

      check("rails", 32'(rails_out), 32'(m_rails));
      check("in_ready", 32'(in_ready), 32'(m_q.size() == 0));
      check("busy", 32'(busy), 32'((m_rails != '0) || m_rtz || (m_q.size() > 0)));
      check("timeout_err", 32'(timeout_err), 32'(m_err));
      check("rails_onehot", 32'(rails_legal(rails_out)), 32'd1);
      check("no_word_to_word",
            32'((prev_dut != '0) && (rails_out != '0) && (rails_out != prev_dut)), 32'd0);
      prev_dut = rails_out;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic handshake();
    ack_in = 1'b1;
    ticks(SYNC + 1);
    ack_in = 1'b0;
    ticks(SYNC + 1);
  endtask

  task automatic send_one(input logic [W-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin : stim
    logic [W-1:0] w;
    int dly;
    int budget;

    // Reset held with random inputs.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom);
      in_data  = W'($urandom);
      ack_in   = 1'($urandom);
      tick();
      check("rst_rails", 32'(rails_out), 32'h0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);
    end
    in_valid = 1'b0;
    ack_in   = 1'b0;
    rst_n    = 1'b1;
    ticks(2);

    // Single word 0xE4.
    send_one(8'hE4);
    check("single_buf_full", 32'(in_ready), 32'd0);
    tick();
    check("single_rails", 32'(rails_out), 32'h8421);
    ack_in = 1'b1;
    ticks(SYNC);
    check("single_hold_before_ack", 32'(rails_out), 32'h8421);
    tick();
    check("single_null_after_ack", 32'(rails_out), 32'h0);
    check("single_busy_rtz", 32'(busy), 32'd1);
    ack_in = 1'b0;
    ticks(SYNC);
    check("single_busy_before_idle", 32'(busy), 32'd1);
    tick();
    check("single_idle", 32'(busy), 32'd0);

    // Back-to-back 0x00 then 0xFF.
    in_valid = 1'b1;
    in_data  = 8'h00;
    tick();
    in_data = 8'hFF;
    check("b2b_ready_low", 32'(in_ready), 32'd0);
    tick();
    check("b2b_first", 32'(rails_out), 32'h1111);
    check("b2b_drained", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("b2b_second_buffered", 32'(in_ready), 32'd0);
    check("b2b_first_hold", 32'(rails_out), 32'h1111);
    ack_in = 1'b1;
    ticks(SYNC + 1);
    check("b2b_null", 32'(rails_out), 32'h0);
    ack_in = 1'b0;
    ticks(SYNC);
    check("b2b_null_hold", 32'(rails_out), 32'h0);
    tick();
    check("b2b_second", 32'(rails_out), 32'h8888);
    check("b2b_ready_again", 32'(in_ready), 32'd1);
    handshake();
    check("b2b_idle", 32'(busy), 32'd0);

    // Stale ack: word 0x1B held back while ack is high.
    ack_in = 1'b1;
    ticks(SYNC + 1);
    send_one(8'h1B);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stale_rails_null", 32'(rails_out), 32'h0);
    end
    ack_in = 1'b0;
    ticks(SYNC);
    check("stale_still_null", 32'(rails_out), 32'h0);
    tick();
    check("stale_rails", 32'(rails_out), 32'h1248);
    handshake();

    // Watchdog: never ack for TIMEOUT cycles in DATA.
    w = W'($urandom);
    send_one(w);
    tick();
    check("wd_data", 32'(rails_out), 32'(enc(w)));
    ticks(TMO - 1);
    check("wd_not_yet", 32'(timeout_err), 32'd0);
    tick();
`ifdef DI_TX_TIMEOUT_EN
    check("wd_set", 32'(timeout_err), 32'd1);
`else
    check("wd_tied_low", 32'(timeout_err), 32'd0);
`endif
    handshake();
`ifdef DI_TX_TIMEOUT_EN
    check("wd_sticky", 32'(timeout_err), 32'd1);
`else
    check("wd_tied_low_after", 32'(timeout_err), 32'd0);
`endif

    // Asynchronous reset mid-DATA.
    w = W'($urandom);
    send_one(w);
    tick();
    check("mid_data", 32'(rails_out), 32'(enc(w)));
    rst_n = 1'b0;
    #1;
    check("async_rst_rails", 32'(rails_out), 32'h0);
    check("async_rst_ready", 32'(in_ready), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_err", 32'(timeout_err), 32'd0);
    ticks(2);
    rst_n = 1'b1;
    ticks(2);

    // Random soak with a random-delay four-phase receiver.
    dly = 0;
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_data  = W'($urandom);
      if ((rails_out != '0) != ack_in) begin
        if (dly == 0) begin
          ack_in = ~ack_in;
          dly    = $urandom_range(0, 5);
        end else begin
          dly--;
        end
      end
      tick();
    end

    // Drain, bounded.
    in_valid = 1'b0;
    budget   = 200;
    while ((busy || ack_in) && (budget > 0)) begin
      if ((rails_out != '0) != ack_in) ack_in = ~ack_in;
      tick();
      budget--;
    end
    check("drain_complete", 32'(busy || ack_in), 32'd0);
    ticks(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/di_tx_1of4.md
# di_tx_1of4

Synchronous transmitter for the delay-insensitive 1-of-4 four-phase link. It takes parallel words over a valid/ready interface, encodes each 2-bit digit as one hot rail out of four, and runs the return-to-zero handshake against an asynchronous acknowledge. It is the sending end for the C-element completion-detect receivers on the user IO pins, and sits between core logic and the rail pads.

## Interface
- `WIDTH`, default 8: data word width. Must be even. Gives WIDTH/2 digit groups and 2*WIDTH rails.
- `SYNC_STAGES`, default 2: number of flops in the `ack_in` synchronizer. Must be ≥2.
- `TIMEOUT`, default 255: watchdog limit in cycles. Used only with `DI_TX_TIMEOUT_EN`.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in WIDTH: word to send.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the holding buffer is empty. A word is accepted on a `clk` edge where `in_valid && in_ready`.
- `rails_out` out 2*WIDTH: registered rails. Group g occupies bits [4g+3:4g].
- `ack_in` in 1: acknowledge from the receiver. Asynchronous to `clk`.
- `busy` out 1: asserted whenever the FSM is not IDLE or the buffer is full.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- **Encoding:** for digit v = `in_data[2g+1:2g]`, rail 4g+v is 1 and the other three rails of group g are 0. The all-zero rail vector is NULL.
- **Holding buffer:** one entry.
  - Fills on an accept.
  - Empties on the edge where the FSM moves into DATA.
  - `in_ready` = buffer empty.
- **Synchronizer:** `ack_s` is `ack_in` after SYNC_STAGES flops. The FSM uses only `ack_s`.
- **FSM states** (all state is registered):
  - IDLE: `rails_out` = NULL. If the buffer is full and `ack_s`=0, load the encoded word into `rails_out`, empty the buffer, and go to DATA. If `ack_s`=1, stay in IDLE; this is a stale ack and nothing is sent.
  - DATA: hold `rails_out`. When `ack_s`=1, drive `rails_out` to NULL and go to NULL.
  - NULL: hold NULL. When `ack_s`=0, go to DATA if the buffer is full (back-to-back, loading it in the same edge), otherwise go to IDLE.
- **Rail invariants:**
  - `rails_out` only ever changes between NULL and a valid codeword.
  - It never goes from one codeword directly to another.
  - Each group never has more than one rail high.
- **Simultaneous events:** an accept into an empty buffer on the same edge the FSM drains the buffer is not possible, because `in_ready` was 0. An accept on the edge that empties the buffer cannot occur either. So at most one accept happens per buffer cycle.
- **Reset (asserted at any time, including mid-handshake):**
  - `rails_out` = 0, state = IDLE, buffer empty.
  - `in_ready`=1 after reset releases.
  - Synchronizer flops = 0.
  - `timeout_err`=0, watchdog counter = 0.
  - The in-flight word is discarded.

## Timing
- **Accept to rails:** a word accepted at edge N is visible on `rails_out` after edge N+1, provided the FSM is IDLE and `ack_s`=0.
- **Ack to NULL:** `ack_in` rising is synchronized in SYNC_STAGES edges. `rails_out` goes NULL on the next edge, so SYNC_STAGES+1 edges after the first edge that samples `ack_in` high.
- **Ack low to next word:** the same SYNC_STAGES+1 edges apply from `ack_in` falling to the next codeword when the buffer is full.
- **Throughput:** at most one word per 2*(SYNC_STAGES+1) cycles plus the receiver's ack latency.
- **Sampling rule:** `in_data` is sampled only on the accept edge. Changes to `in_data` at other times have no effect.

## Configuration
- Controlled by the `DI_TX_TIMEOUT_EN` macro.
- **Defined:**
  - A counter of ⌈log2(TIMEOUT+1)⌉ bits counts consecutive cycles spent in DATA or NULL without a state change.
  - It clears on every state change.
  - When it reaches TIMEOUT, `timeout_err` sets and stays set until reset.
  - The FSM keeps waiting; it does not abort the handshake.
- **Undefined:** no counter is built and `timeout_err` is tied to 0. The port is always present.

## Structure
- **Package `di_tx_pkg`:**
  - State enum (IDLE, DATA, NULL).
  - Rail-group width constant (4).
  - Pure function `encode_1of4(word)` returning 2*WIDTH rails.
  - NULL constant helper.
- **Sub-module `di_sync`:** a parameterized SYNC_STAGES-deep synchronizer with asynchronous reset to 0. The top instantiates one for `ack_in`.

## Test plan
- **Reset:** hold `rst_n`=0 with random inputs. Expect `rails_out`=0, `in_ready`=1, `busy`=0, `timeout_err`=0. Then assert reset mid-DATA: `rails_out` must be 0 immediately, without waiting for a clock edge.
- **Single word:** WIDTH=8, accept 0xE4. Expect `rails_out`=0x8421 after the next edge. Raise `ack_in`: `rails_out`=0 after 3 edges. Drop `ack_in`: state returns to IDLE after 3 edges.
- **Back-to-back:** send 0x00 then 0xFF, with the second accepted while in DATA. Expect rails 0x1111, then NULL, then 0x8888, with a NULL phase between them and `in_ready`=0 until the buffer drains.
- **Stale ack:** hold `ack_in`=1, then accept 0x1B. Expect `rails_out` to stay 0 until `ack_in` falls. Expect 0x1248 SYNC_STAGES+1 edges after `ack_in` falls.
- **Watchdog:** with `DI_TX_TIMEOUT_EN` and TIMEOUT=10, send a word and never ack. Expect `timeout_err`=1 after the 10th cycle in DATA, staying set through a later ack. Without the macro, `timeout_err` stays 0.
- **Random soak:** run a random ack responder with random delays. A checker confirms every codeword decodes back to the sent word, no group is ever multi-hot, and NULL separates every pair of codewords.
